// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed display blocks.
// Contents: default scan timing constants, counter-width helper,
//           slot state enum and the pin polarity helper.
package seg_pkg;

   localparam int unsigned SEG_DEFAULT_PRESCALE = 50000;
   localparam int unsigned SEG_DEFAULT_BLANK    = 16;
   localparam int unsigned SEG_DEFAULT_CNT_W    = $clog2(SEG_DEFAULT_PRESCALE);

   // Phase inside one digit slot.
   typedef enum logic {
      SLOT_BLANK = 1'b0,
      SLOT_DRIVE = 1'b1
   } slot_state_e;

   // Width of a counter that runs 0..prescale-1 (at least one bit).
   function automatic int unsigned seg_cnt_w(input int unsigned prescale);
      return (prescale > 1) ? $clog2(prescale) : 1;
   endfunction

   // Convert a logical (1 = lit/selected) vector to pin polarity.
   // Callers truncate the result to their own width (<= 32 bits).
   function automatic logic [31:0] apply_pol(input logic [31:0] value,
                                            input logic        active_low);
      return active_low ? ~value : value;
   endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Digit-slot timebase for seg_scan_mux.
// Ports:
//   clk, rst          - system clock, synchronous active-high reset
//   i_bright          - frame brightness (only with SEG_SCAN_BRIGHTNESS_EN)
//   o_idx             - digit index of the current slot (registered)
//   o_frame_start_c   - cnt==0 and idx==0 in the current cycle
//   o_in_drive_c      - current cycle lies in the drive window
module seg_slot_timer
   import seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned PRESCALE     = SEG_DEFAULT_PRESCALE,
   parameter int unsigned BLANK_CYCLES = SEG_DEFAULT_BLANK,
   parameter int unsigned CNT_W        = SEG_DEFAULT_CNT_W,
   parameter int unsigned IDX_W        = 2
) (
   input  logic             clk,
   input  logic             rst,
`ifdef SEG_SCAN_BRIGHTNESS_EN
   input  logic [3:0]       i_bright,
`endif
   output logic [IDX_W-1:0] o_idx,
   output logic             o_frame_start_c,
   output logic             o_in_drive_c
);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [IDX_W-1:0] w_idx_nxt;
   slot_state_e      w_state;

   // Counter state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
         o_idx <= '0;
      end else begin
         r_cnt <= w_cnt_nxt;
         o_idx <= w_idx_nxt;
      end
   end

   // Next count / digit index and slot phase decode.
   always_comb begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
      w_idx_nxt = o_idx;
      if (r_cnt == CNT_W'(PRESCALE - 1)) begin
         w_cnt_nxt = '0;
         w_idx_nxt = (o_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : o_idx + IDX_W'(1);
      end
      w_state = (32'(r_cnt) < 32'(BLANK_CYCLES)) ? SLOT_BLANK : SLOT_DRIVE;
   end

   assign o_frame_start_c = (r_cnt == '0) && (o_idx == '0);

`ifdef SEG_SCAN_BRIGHTNESS_EN
   logic [31:0] w_lhs;
   logic [31:0] w_rhs;

   // Drive window shortened to (bright+1)/16 of the post-blank slot.
   // w_lhs underflows in BLANK, but the state term masks that case.
   always_comb begin
      w_lhs        = (32'(r_cnt) - 32'(BLANK_CYCLES)) << 4;
      w_rhs        = (32'(i_bright) + 32'd1) * 32'(PRESCALE - BLANK_CYCLES);
      o_in_drive_c = (w_state == SLOT_DRIVE) && (w_lhs < w_rhs);
   end
`else
   assign o_in_drive_c = (w_state == SLOT_DRIVE);
`endif

endmodule

// File: rtl/seg_scan_mux.sv
// N-digit multiplexed 7-segment/LED scanner with blanking dead-time and
// per-frame snapshot of segment data.
// Optional feature macro: SEG_SCAN_BRIGHTNESS_EN (adds brightness[3:0]).
// Ports:
//   clk, rst    - system clock, synchronous active-high reset
//   segData     - per-digit patterns, digit i at [i*SEG_W +: SEG_W], 1 = lit
//   digitEn     - per-digit enable (disabled digits stay dark in their slot)
//   brightness  - drive-window length, captured per frame (macro only)
//   anode       - digit select in pin polarity, registered
//   ledx        - segment drive in pin polarity, registered
//   frameStart  - one-cycle pulse when the frame snapshot is taken
module seg_scan_mux
   import seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned SEG_W        = 8,
   parameter int unsigned PRESCALE     = SEG_DEFAULT_PRESCALE,
   parameter int unsigned BLANK_CYCLES = SEG_DEFAULT_BLANK,
   parameter int unsigned ACTIVE_LOW   = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_DIGITS*SEG_W-1:0] segData,
   input  logic [NUM_DIGITS-1:0]       digitEn,
`ifdef SEG_SCAN_BRIGHTNESS_EN
   input  logic [3:0]                  brightness,
`endif
   output logic [NUM_DIGITS-1:0]       anode,
   output logic [SEG_W-1:0]            ledx,
   output logic                        frameStart
);

   localparam int unsigned CNT_W    = seg_cnt_w(PRESCALE);
   localparam int unsigned IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic        POL_LOW  = (ACTIVE_LOW != 0);

   logic [SEG_W-1:0]      r_seg [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] r_en;
   logic [IDX_W-1:0]      w_idx;
   logic                  w_frame_start;
   logic                  w_in_drive;
   logic [NUM_DIGITS-1:0] w_anode_log;
   logic [SEG_W-1:0]      w_seg_log;

`ifdef SEG_SCAN_BRIGHTNESS_EN
   logic [3:0]            r_bright;
`endif

   seg_slot_timer #(
      .NUM_DIGITS   (NUM_DIGITS),
      .PRESCALE     (PRESCALE),
      .BLANK_CYCLES (BLANK_CYCLES),
      .CNT_W        (CNT_W),
      .IDX_W        (IDX_W)
   ) u_timer (
      .clk             (clk),
      .rst             (rst),
`ifdef SEG_SCAN_BRIGHTNESS_EN
      .i_bright        (r_bright),
`endif
      .o_idx           (w_idx),
      .o_frame_start_c (w_frame_start),
      .o_in_drive_c    (w_in_drive)
   );

   // Logical select/segments for the current cycle; dark unless driving an enabled digit.
   always_comb begin
      w_anode_log = '0;
      w_seg_log   = '0;
      if (w_in_drive && r_en[w_idx]) begin
         w_anode_log[w_idx] = 1'b1;
         w_seg_log          = r_seg[w_idx];
      end
   end

   // Frame snapshot and polarity-adjusted output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            r_seg[i] <= '0;
         end
         r_en       <= '0;
`ifdef SEG_SCAN_BRIGHTNESS_EN
         r_bright   <= '0;
`endif
         frameStart <= 1'b0;
         anode      <= NUM_DIGITS'(apply_pol(32'd0, POL_LOW));
         ledx       <= SEG_W'(apply_pol(32'd0, POL_LOW));
      end else begin
         frameStart <= w_frame_start;
         if (w_frame_start) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
               r_seg[i] <= segData[i*SEG_W +: SEG_W];
            end
            r_en <= digitEn;
`ifdef SEG_SCAN_BRIGHTNESS_EN
            r_bright <= brightness;
`endif
         end
         anode <= NUM_DIGITS'(apply_pol(32'(w_anode_log), POL_LOW));
         ledx  <= SEG_W'(apply_pol(32'(w_seg_log), POL_LOW));
      end
   end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux: NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2,
// ACTIVE_LOW=1. With SEG_SCAN_BRIGHTNESS_EN a second instance (PRESCALE=34,
// brightness=3) checks the shortened drive window.
module tb_seg_scan_mux;

   localparam logic [31:0] SEG_INIT = 32'h030C30C0;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] segData;
   logic [3:0]  digitEn;
   logic [3:0]  anode;
   logic [7:0]  ledx;
   logic        frameStart;

   int n_cmp  = 0;
   int n_fail = 0;
   int edge_n = 0;

   always #5 clk = ~clk;

`ifdef SEG_SCAN_BRIGHTNESS_EN
   logic [3:0]  bright_a;
   logic [3:0]  bright_b;
   logic [3:0]  anode_b;
   logic [7:0]  ledx_b;
   logic        fs_b;
`endif

   seg_scan_mux #(
      .NUM_DIGITS(4), .SEG_W(8), .PRESCALE(8), .BLANK_CYCLES(2), .ACTIVE_LOW(1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .segData    (segData),
      .digitEn    (digitEn),
`ifdef SEG_SCAN_BRIGHTNESS_EN
      .brightness (bright_a),
`endif
      .anode      (anode),
      .ledx       (ledx),
      .frameStart (frameStart)
   );

`ifdef SEG_SCAN_BRIGHTNESS_EN
   seg_scan_mux #(
      .NUM_DIGITS(4), .SEG_W(8), .PRESCALE(34), .BLANK_CYCLES(2), .ACTIVE_LOW(1)
   ) dut_b (
      .clk        (clk),
      .rst        (rst),
      .segData    (segData),
      .digitEn    (digitEn),
      .brightness (bright_b),
      .anode      (anode_b),
      .ledx       (ledx_b),
      .frameStart (fs_b)
   );
`endif

   typedef struct {
      int         first;
      int         last;
      logic [3:0] anode;
      logic [7:0] ledx;
      logic       fs;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s edge=%0d got=0x%0h expected=0x%0h", name, edge_n, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      edge_n++;
   endtask

   task automatic tick_to(input int target);
      while (edge_n < target) tick();
   endtask

   // Hold reset for three edges (checking the reset outputs), then release.
   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) begin
         tick();
         chk("rst_anode", 32'(anode), 32'hF);
         chk("rst_ledx",  32'(ledx),  32'hFF);
         chk("rst_fs",    32'(frameStart), 32'h0);
      end
      @(negedge clk);
      rst    = 1'b0;
      edge_n = 0;
   endtask

   // First frame after release, edges 1..33, against the vector table.
   task automatic run_table();
      for (int e = 1; e <= 33; e++) begin
         tick();
         for (int t = 0; t < 10; t++) begin
            if (e >= tbl[t].first && e <= tbl[t].last) begin
               chk("tbl_anode", 32'(anode),      32'(tbl[t].anode));
               chk("tbl_ledx",  32'(ledx),       32'(tbl[t].ledx));
               chk("tbl_fs",    32'(frameStart), 32'(tbl[t].fs));
            end
         end
      end
   endtask

   initial begin
      int got;
      int fstart;
      int last_fs;
      int off_run;
      int nfs;
      logic [3:0] act;
      logic [3:0] last_act;

      tbl[0] = '{1,  1,  4'hF, 8'hFF, 1'b1};
      tbl[1] = '{2,  2,  4'hF, 8'hFF, 1'b0};
      tbl[2] = '{3,  8,  4'hE, 8'h3F, 1'b0};
      tbl[3] = '{9,  10, 4'hF, 8'hFF, 1'b0};
      tbl[4] = '{11, 16, 4'hD, 8'hCF, 1'b0};
      tbl[5] = '{17, 18, 4'hF, 8'hFF, 1'b0};
      tbl[6] = '{19, 24, 4'hB, 8'hF3, 1'b0};
      tbl[7] = '{25, 26, 4'hF, 8'hFF, 1'b0};
      tbl[8] = '{27, 32, 4'h7, 8'hFC, 1'b0};
      tbl[9] = '{33, 33, 4'hF, 8'hFF, 1'b1};

      rst     = 1'b1;
      segData = SEG_INIT;
      digitEn = 4'hF;
`ifdef SEG_SCAN_BRIGHTNESS_EN
      bright_a = 4'hF;
      bright_b = 4'h3;
`endif

      // Reset, then the first frame from the table.
      apply_reset();
      run_table();

      // Mid-frame segData change is invisible until the next snapshot.
      tick_to(36);
      chk("t3_before", 32'(ledx), 32'h3F);
      segData[7:0] = 8'hFF;
      for (int e = 37; e <= 40; e++) begin
         tick();
         chk("t3_hold_anode", 32'(anode), 32'hE);
         chk("t3_hold_ledx",  32'(ledx),  32'h3F);
      end
      tick_to(64);
      chk("t3_no_fs", 32'(frameStart), 32'h0);
      tick();
      chk("t3_fs", 32'(frameStart), 32'h1);
      tick_to(66);
      chk("t3_blank", 32'(anode), 32'hF);
      for (int e = 67; e <= 72; e++) begin
         tick();
         chk("t3_new_anode", 32'(anode), 32'hE);
         chk("t3_new_ledx",  32'(ledx),  32'h00);
      end
      segData = SEG_INIT;

      // Reset during digit 2's drive window; scan restarts at digit 0.
      tick_to(85);
      chk("t2_pre_anode", 32'(anode), 32'hB);
      chk("t2_pre_ledx",  32'(ledx),  32'hF3);
      rst = 1'b1;
      tick();
      chk("t2_mid_anode", 32'(anode), 32'hF);
      chk("t2_mid_ledx",  32'(ledx),  32'hFF);
      chk("t2_mid_fs",    32'(frameStart), 32'h0);
      @(negedge clk);
      rst    = 1'b0;
      edge_n = 0;
      run_table();

      // Digit 2 disabled: its slot stays dark, frame period unchanged.
      digitEn = 4'b1011;
      got = 0;
      for (int i = 0; i < 64; i++) begin
         tick();
         if (frameStart) begin
            got = 1;
            break;
         end
      end
      chk("t4_fs_found", 32'(got), 32'h1);
      chk("t4_fs_edge",  32'(edge_n), 32'd65);
      fstart = edge_n;
      for (int k = 1; k <= 31; k++) begin
         tick();
         chk("t4_no_fs", 32'(frameStart), 32'h0);
         if (k >= 2 && k <= 7) begin
            chk("t4_d0_anode", 32'(anode), 32'hE);
            chk("t4_d0_ledx",  32'(ledx),  32'h3F);
         end
         if (k >= 10 && k <= 15) chk("t4_d1_anode", 32'(anode), 32'hD);
         if (k >= 16 && k <= 23) begin
            chk("t4_d2_anode", 32'(anode), 32'hF);
            chk("t4_d2_ledx",  32'(ledx),  32'hFF);
         end
         if (k >= 26 && k <= 31) begin
            chk("t4_d3_anode", 32'(anode), 32'h7);
            chk("t4_d3_ledx",  32'(ledx),  32'hFC);
         end
      end
      tick();
      chk("t4_period", 32'(edge_n - fstart), 32'd32);
      chk("t4_fs_next", 32'(frameStart), 32'h1);
      digitEn = 4'hF;

      // Ten frames of random data: one-hot, dead-time and frame period.
      last_fs  = edge_n;
      last_act = 4'h0;
      off_run  = 0;
      nfs      = 0;
      for (int i = 0; i < 320; i++) begin
         segData = $urandom;
         digitEn = 4'($urandom_range(0, 15));
         tick();
         act = ~anode;
         chk("t5_onehot", 32'($onehot0(act)), 32'h1);
         if (act == 4'h0) begin
            off_run++;
            chk("t5_dark_ledx", 32'(ledx), 32'hFF);
         end else begin
            if (last_act != 4'h0 && act != last_act)
               chk("t5_gap", 32'(off_run >= 2), 32'h1);
            last_act = act;
            off_run  = 0;
         end
         if (frameStart) begin
            nfs++;
            chk("t5_period", 32'(edge_n - last_fs), 32'd32);
            last_fs = edge_n;
         end
      end
      chk("t5_frames", 32'(nfs), 32'd10);

`ifdef SEG_SCAN_BRIGHTNESS_EN
      // PRESCALE=34, brightness=3: 8 driven cycles per slot from slot offset 2.
      segData = SEG_INIT;
      digitEn = 4'hF;
      apply_reset();
      for (int e = 1; e <= 136; e++) begin
         int c;
         int d;
         logic [3:0] exp_an;
         logic [7:0] exp_led;
         logic [31:0] seg_copy;
         tick();
         c        = (e - 1) % 34;
         d        = (e - 1) / 34;
         seg_copy = SEG_INIT;
         exp_an   = 4'hF;
         exp_led  = 8'hFF;
         if (c >= 2 && c < 10) begin
            exp_an  = ~(4'b0001 << d);
            exp_led = ~seg_copy[d*8 +: 8];
         end
         chk("t6_anode", 32'(anode_b), 32'(exp_an));
         chk("t6_ledx",  32'(ledx_b),  32'(exp_led));
         chk("t6_fs",    32'(fs_b),    32'(e == 1));
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
